// File: rtl/operation_manager.sv
// operation_manager: sample sequencer walking every (octave, operation, bin) triple once per sample

// operation_counter: walks bins, then add/subtract pass, then octaves; clears when disabled
module operation_counter #(
  parameter int OCT  = 5,
  parameter int BINS = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_enable,
  output logic [$clog2(OCT)-1:0]  o_octave,
  output logic                    o_operation,
  output logic [$clog2(BINS)-1:0] o_bin,
  output logic                    o_finished
);
  localparam int OW = $clog2(OCT);
  localparam int BW = $clog2(BINS);
  logic [OW-1:0] r_octave;
  logic          r_operation;
  logic [BW-1:0] r_bin;
  logic          w_bin_last;
  logic          w_oct_last;
  assign w_bin_last  = r_bin == BW'(BINS - 1);
  assign w_oct_last  = r_octave == OW'(OCT - 1);
  assign o_finished  = w_bin_last && r_operation && w_oct_last;
  assign o_octave    = r_octave;
  assign o_operation = r_operation;
  assign o_bin       = r_bin;
  // Advance the triple while enabled; a disabled counter parks at (0,0,0)
  always_ff @(posedge clk or posedge rst) begin
    if (rst || !i_enable) begin
      r_bin       <= '0;
      r_operation <= 1'b0;
      r_octave    <= '0;
    end else begin
      r_bin <= w_bin_last ? '0 : r_bin + 1'b1;
      if (w_bin_last) r_operation <= ~r_operation;
      if (w_bin_last && r_operation) r_octave <= w_oct_last ? '0 : r_octave + 1'b1;
    end
  end
endmodule

// octave_storage: per-octave sample shift register, newest sample in entry 0
module octave_storage #(
  parameter int N    = 16,
  parameter int SIZE = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [N-1:0] i_new_sample,
  input  logic                i_write_sample,
  output logic signed [N-1:0] o_sample0,
  output logic signed [N-1:0] o_sample1,
  output logic signed [N-1:0] o_oldest_sample
);
  logic signed [N-1:0] r_mem [SIZE];
  assign o_sample0       = r_mem[0];
  assign o_sample1       = r_mem[1];
  assign o_oldest_sample = r_mem[SIZE-1];
  // Shift the history by one entry on each write strobe, otherwise hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SIZE; i++) r_mem[i] <= '0;
    end else if (i_write_sample) begin
      r_mem[0] <= i_new_sample;
      for (int i = 1; i < SIZE; i++) r_mem[i] <= r_mem[i-1];
    end
  end
endmodule

module operation_manager #(
  parameter int OCT  = 5,
  parameter int BINS = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_sample_ready,
  output logic                    o_ready,
  output logic                    o_write_sample,
  output logic                    o_finished_processing,
  output logic [$clog2(OCT)-1:0]  o_octave,
  output logic                    o_operation,
  output logic [$clog2(BINS)-1:0] o_bin
);
  typedef enum logic [1:0] {IDLE, WRITE, PROCESS, DONE} state_t;
  state_t r_state;
  state_t w_next;
  logic   w_finished;
  assign o_ready               = r_state == IDLE;
  assign o_write_sample        = r_state == WRITE;
  assign o_finished_processing = r_state == DONE;
  operation_counter #(.OCT(OCT), .BINS(BINS)) u_counter (
    .clk        (clk),
    .rst        (rst),
    .i_enable   (r_state == PROCESS),
    .o_octave   (o_octave),
    .o_operation(o_operation),
    .o_bin      (o_bin),
    .o_finished (w_finished)
  );
  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  // Next state: wait for a sample, strobe it in, sweep all triples, pulse done
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = i_sample_ready ? WRITE : IDLE;
      WRITE:   w_next = PROCESS;
      PROCESS: w_next = w_finished ? DONE : PROCESS;
      default: w_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_operation_manager.sv
// tb_operation_manager: directed vector checks of the manager sequence and sample storage
module tb_operation_manager;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sr = 1'b0;
  logic ready, wr, fin, op;
  logic [2:0] oct;
  logic [4:0] bin;
  logic st_wr = 1'b0;
  logic signed [15:0] st_din = '0;
  logic signed [15:0] s0, s1, old;
  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  operation_manager #(.OCT(5), .BINS(24)) dut (
    .clk(clk), .rst(rst), .i_sample_ready(sr), .o_ready(ready), .o_write_sample(wr),
    .o_finished_processing(fin), .o_octave(oct), .o_operation(op), .o_bin(bin)
  );

  octave_storage #(.N(16), .SIZE(8)) u_st (
    .clk(clk), .rst(rst), .i_new_sample(st_din), .i_write_sample(st_wr),
    .o_sample0(s0), .o_sample1(s1), .o_oldest_sample(old)
  );

  typedef struct {
    logic wr;
    int   din;
    int   e0;
    int   e1;
    int   eo;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // {ready, write, fin, octave, operation, bin} expected at phase p of a sample
  function automatic logic [11:0] exp_at(input int p);
    int k;
    if (p == 0) return {3'b010, 9'd0};
    if (p <= 240) begin
      k = p - 1;
      return {3'b000, 3'(k / 48), 1'((k / 24) % 2), 5'(k % 24)};
    end
    if (p == 241) return {3'b001, 9'd0};
    return {3'b100, 9'd0};
  endfunction

  function automatic logic [11:0] mgr_word();
    return {ready, wr, fin, oct, op, bin};
  endfunction

  task automatic run_sample(input string name, input bit hold);
    for (int p = 0; p < 243; p++) begin
      @(negedge clk);
      chk($sformatf("%s_p%0d", name, p), int'(mgr_word()), int'(exp_at(p)));
      if (p == 0 && !hold) sr = 1'b0;
    end
  endtask

  vec_t v[14];

  initial begin
    v[0]  = '{1, 100,   100,   0,    0};
    v[1]  = '{1, 222,   222,   100,  0};
    v[2]  = '{1, -333,  -333,  222,  0};
    v[3]  = '{0, -1,    -333,  222,  0};
    v[4]  = '{0, -1,    -333,  222,  0};
    v[5]  = '{1, 100,   100,   -333, 0};
    v[6]  = '{1, 222,   222,   100,  0};
    v[7]  = '{1, 333,   333,   222,  0};
    v[8]  = '{1, 444,   444,   333,  0};
    v[9]  = '{1, 555,   555,   444,  100};
    v[10] = '{1, 666,   666,   555,  222};
    v[11] = '{1, 777,   777,   666,  -333};
    v[12] = '{1, 888,   888,   777,  100};
    v[13] = '{1, 9999,  9999,  888,  222};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_mgr", int'(mgr_word()), int'({3'b100, 9'd0}));
    chk("reset_st", int'(s0) | int'(s1) | int'(old), 0);
    for (int i = 0; i < 14; i++) begin
      st_wr = v[i].wr;
      st_din = 16'(v[i].din);
      @(negedge clk);
      chk($sformatf("st%0d_s0", i), int'(s0), v[i].e0);
      chk($sformatf("st%0d_s1", i), int'(s1), v[i].e1);
      chk($sformatf("st%0d_old", i), int'(old), v[i].eo);
    end
    st_wr = 1'b0;
    sr = 1'b1;
    run_sample("single", 1'b0);
    @(negedge clk);
    chk("single_idle_stays", int'(mgr_word()), int'({3'b100, 9'd0}));
    sr = 1'b1;
    run_sample("b2b_a", 1'b1);
    run_sample("b2b_b", 1'b1);
    sr = 1'b0;
    @(negedge clk);
    chk("b2b_idle", int'(mgr_word()), int'({3'b100, 9'd0}));
    sr = 1'b1;
    @(negedge clk);
    sr = 1'b0;
    st_wr = 1'b1;
    st_din = 16'sd77;
    repeat (60) @(negedge clk);
    chk("pre_rst_mgr", int'(mgr_word()), int'(exp_at(60)));
    chk("pre_rst_st", int'(s0), 77);
    st_wr = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_triple", int'({wr, fin, oct, op, bin}), 0);
    chk("rst_ready", int'(ready), 1);
    chk("rst_st", int'(s0) | int'(s1) | int'(old), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst", int'(mgr_word()), int'({3'b100, 9'd0}));
    chk("post_rst_st", int'(s0) | int'(s1) | int'(old), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
